// File: rtl/ris_pkg.sv
// Shared constants for the RIS element array: code widths, the state->GPIO drive table,
// the default frame header and the reporter FSM encoding.
package ris_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned GPIO_W  = 2;
  localparam int unsigned N_CODES = 1 << STATE_W;

  // Entry s (bits [2s+1:2s]) is the GPIO pattern driven for RIS state code s.
  localparam logic [N_CODES*GPIO_W-1:0] STATE2GPIO = {2'b11, 2'b10, 2'b01, 2'b00};

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } ris_fsm_e;

  function automatic bit state2gpio_bijective();
    for (int a = 0; a < N_CODES; a++) begin
      for (int b = a + 1; b < N_CODES; b++) begin
        if (STATE2GPIO[a*GPIO_W +: GPIO_W] == STATE2GPIO[b*GPIO_W +: GPIO_W]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/ris_gpio_inverse.sv
// Combinational inverse of the state->GPIO table: recovers the RIS state code that
// produces a given 2-bit GPIO drive pattern.
module ris_gpio_inverse
  import ris_pkg::*;
(
  input  logic [GPIO_W-1:0]  i_gpio,
  output logic [STATE_W-1:0] o_state
);

  always_comb begin
    o_state = '0;
    for (int s = 0; s < N_CODES; s++) begin
      if (STATE2GPIO[s*GPIO_W +: GPIO_W] == i_gpio) o_state = STATE_W'(s);
    end
  end

endmodule

// File: rtl/ris_state_reporter.sv
// Snapshots the element GPIO lines, maps them back to state codes and streams a framed
// status report (header, packed codes, XOR checksum) over a valid/ready byte interface.
module ris_state_reporter
  import ris_pkg::*;
#(
  parameter int unsigned N_ELEM   = 16,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*N_ELEM-1:0]   gpio_in,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned N_BYTES = N_ELEM / 4;
  localparam int unsigned IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  if ((N_ELEM % 4 != 0) || (N_ELEM < 4)) begin : g_bad_n_elem
    $error("ris_state_reporter: N_ELEM must be a multiple of 4 and at least 4");
  end
  if (!state2gpio_bijective()) begin : g_bad_table
    $error("ris_state_reporter: STATE2GPIO table is not bijective");
  end

  ris_fsm_e              r_state;
  logic [2*N_ELEM-1:0]   r_snap;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_csum;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_busy;
  logic                  r_done;

  logic [2*N_ELEM-1:0]   w_codes;
  logic [7:0]            w_cur_byte;
  logic [7:0]            w_nxt_byte;
  logic                  w_hs;
  logic                  w_last;

  for (genvar g = 0; g < N_ELEM; g++) begin : g_inv
    ris_gpio_inverse u_inv (
      .i_gpio  (r_snap[2*g +: 2]),
      .o_state (w_codes[2*g +: 2])
    );
  end

  // The byte after the current one is preloaded into tx_data so outputs stay registered.
  always_comb begin
    w_cur_byte = '0;
    w_nxt_byte = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      if (k == int'(r_idx))     w_cur_byte = w_codes[8*k +: 8];
      if (k == int'(r_idx) + 1) w_nxt_byte = w_codes[8*k +: 8];
    end
  end

  assign w_hs   = r_tx_valid & tx_ready;
  assign w_last = (r_idx == IDX_W'(N_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_snap     <= '0;
      r_idx      <= '0;
      r_csum     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_snap     <= gpio_in;
            r_idx      <= '0;
            r_csum     <= '0;
            r_tx_data  <= HDR_BYTE;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_hs) begin
            r_tx_data <= w_cur_byte;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            r_csum <= r_csum ^ w_cur_byte;
            if (w_last) begin
              r_tx_data <= r_csum ^ w_cur_byte;
              r_state   <= ST_CSUM;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_tx_data <= w_nxt_byte;
            end
          end
        end
        ST_CSUM: begin
          if (w_hs) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_ris_state_reporter.sv
// Self-checking bench for ris_state_reporter (N_ELEM=16): a byte scoreboard checks every
// handshake, while the main sequence checks control timing and corner cases.
module tb_ris_state_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] gpio_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  typedef struct packed {
    logic [31:0] gpio;
    logic [47:0] frame;
  } vec_t;

  ris_state_reporter #(
    .N_ELEM   (16),
    .HDR_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .gpio_in  (gpio_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the next expected byte.
  always @(negedge clk) begin
    if (rst === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("tx_byte", {40'd0, tx_data}, {40'd0, mon_exp});
      end
    end
  end

  // Bench-side state->GPIO inverse (identity table).
  function automatic logic [1:0] inv_code(input logic [1:0] g);
    case (g)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [47:0] model_frame(input logic [31:0] g);
    logic [7:0] b [4];
    logic [7:0] cs;
    cs = 8'h00;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) b[k][2*j +: 2] = inv_code(g[8*k + 2*j +: 2]);
      cs = cs ^ b[k];
    end
    return {8'hA5, b[0], b[1], b[2], b[3], cs};
  endfunction

  // Called at posedge+#1; returns at posedge+#1 of the first header cycle.
  task automatic start_frame(input logic [31:0] g, input logic [47:0] f);
    gpio_in = g;
    start   = 1'b1;
    for (int i = 5; i >= 0; i--) exp_q.push_back(f[8*i +: 8]);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("hdr_offer", {37'd0, tx_valid, busy, done, tx_data}, {37'd0, 1'b1, 1'b1, 1'b0, 8'hA5});
  endtask

  task automatic wait_done(input bit check_busy);
    int  busy_cnt;
    bit  found;
    busy_cnt = 1;
    found    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    if (!found) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: got no done pulse, expected one within 40 cycles");
    end else begin
      chk("done_cycle", {45'd0, done, busy, tx_valid}, {45'd0, 3'b100});
      chk("queue_drained", 48'(exp_q.size()), 48'd0);
      if (check_busy) chk("busy_cycles", 48'(busy_cnt), 48'd6);
    end
  endtask

  vec_t vecs [3];

  initial begin
    vecs[0] = '{gpio: 32'h0000_0000, frame: 48'hA5_00_00_00_00_00};
    vecs[1] = '{gpio: 32'h0000_0003, frame: 48'hA5_03_00_00_00_03};
    vecs[2] = '{gpio: 32'hE4E4_E4E4, frame: 48'hA5_E4_E4_E4_E4_00};

    rst      = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b1;
    gpio_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", {37'd0, tx_valid, busy, done, tx_data}, 48'd0);

    // Vectors run back-to-back: each new start lands in the previous frame's done cycle.
    for (int v = 0; v < 3; v++) begin
      start_frame(vecs[v].gpio, vecs[v].frame);
      wait_done(1'b1);
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", {46'd0, done, busy}, 48'd0);

    // Back-pressure while data byte 1 is offered.
    start_frame(32'h1234_5678, model_frame(32'h1234_5678));
    repeat (2) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall_hold", {39'd0, tx_valid, tx_data}, {39'd0, 1'b1, 8'h56});
    end
    tx_ready = 1'b1;
    wait_done(1'b0);

    // Input change after capture and a dropped mid-frame start.
    start_frame(32'h0000_00F0, model_frame(32'h0000_00F0));
    gpio_in = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("no_second_frame", {46'd0, tx_valid, busy}, 48'd0);

    // Reset while data byte 2 is offered.
    start_frame(32'hCAFE_BABE, model_frame(32'hCAFE_BABE));
    repeat (3) @(posedge clk);
    #1;
    chk("byte2_offer", {39'd0, tx_valid, tx_data}, {39'd0, 1'b1, 8'hFE});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_idle", {46'd0, tx_valid, busy}, 48'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_resume", {46'd0, tx_valid, busy}, 48'd0);
    start_frame(32'hCAFE_BABE, model_frame(32'hCAFE_BABE));
    wait_done(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ris_state_reporter.md
# ris_state_reporter

Read-back encoder for the RIS element array. It snapshots the per-element GPIO drive lines, inverse-maps each 2-bit GPIO pattern back to its 2-bit RIS state code, and packs the codes into a framed byte stream. The stream goes through a valid/ready handshake to the UART transmitter, so the host can confirm over RS232 which phase state every element holds. It is the encode-side counterpart of the per-element state→GPIO decode.

## Interface
Parameters:
- N_ELEM, 16: number of RIS elements reported; must be a multiple of 4, ≥4.
- HDR_BYTE, 8'hA5: frame header byte.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle request to emit one status frame; ignored while busy.
- gpio_in  in  2*N_ELEM  GPIO drive lines; element i occupies bits [2i+1:2i].
- tx_data  out  8  byte offered to the UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte. A handshake occurs when tx_valid and tx_ready are both high at a clock edge.
- busy  out  1  frame in progress (from the start capture through the final handshake).
- done  out  1  one-cycle pulse after the checksum byte is accepted.

## Operation
- Frame is N_BYTES+2 bytes, where N_BYTES = N_ELEM/4:
  - header HDR_BYTE;
  - N_BYTES data bytes;
  - checksum byte.
- Data byte k packs the state codes of elements 4k..4k+3. Element 4k is in bits [1:0], element 4k+3 is in bits [7:6].
- Checksum = XOR of all data bytes. The header is excluded.
- State code of each element = inverse of the state→GPIO table. The current table is 0→00, 1→01, 2→10, 3→11. The table must be bijective, and an elaboration-time check enforces this.
- FSM states:
  - IDLE: tx_valid=0, busy=0. When start=1, capture gpio_in into a snapshot register, load byte index 0, clear the checksum accumulator, and go to HDR.
  - HDR: tx_data=HDR_BYTE, tx_valid=1. On handshake, go to DATA.
  - DATA: tx_data = packed byte[idx], tx_valid=1. On handshake, XOR the byte into the checksum and increment idx. After the handshake on idx=N_BYTES-1, go to CSUM.
  - CSUM: tx_data = checksum, tx_valid=1. On handshake, go to IDLE and pulse done.
- All encoding uses the snapshot. Changes on gpio_in after the capture edge do not affect the frame in progress.
- start while busy=1 is dropped, not queued.
- tx_data must not change while tx_valid=1 and tx_ready=0.
- tx_valid never drops without a handshake, except on rst.

## Timing
- Reset values:
  - state=IDLE;
  - tx_valid=0, tx_data=8'h00;
  - busy=0, done=0;
  - snapshot, idx and checksum = 0.
- start sampled high at edge t: busy=1 and tx_valid=1 (header) from t+1.
- With tx_ready held high, one byte is accepted per cycle. The last handshake is at edge t+N_BYTES+2, and done=1 for the cycle after it, with busy=0 in that same cycle.
- A new start is accepted in the cycle done is high, giving back-to-back frames with a one-cycle tx_valid gap.
- rst during any state aborts the frame. At the next edge the block is in IDLE with tx_valid=0, and the partial frame is not resumed.
- Registered outputs only; no combinational path from tx_ready or start to any output.

## Structure
- Package ris_pkg holds:
  - the RIS state code width (2) and GPIO width (2);
  - the state→GPIO table constant;
  - HDR_BYTE default;
  - the FSM state enum.
- Sub-module ris_gpio_inverse is a combinational inverse lookup from a 2-bit GPIO pattern to a 2-bit state code. It is instantiated N_ELEM times via generate on the snapshot.

## Test plan (N_ELEM=16, tx_ready=1 unless stated)
- All elements state 0, start pulse → bytes A5,00,00,00,00,00; done one cycle after the 6th handshake; busy high for exactly 6 cycles.
- Element 0=3, all others 0 → A5,03,00,00,00,03.
- Element i = i%4 → A5,E4,E4,E4,E4,00.
- tx_ready low for 3 cycles while data byte 1 is offered → tx_valid and tx_data are held stable for those cycles; the full frame is still correct.
- gpio_in flipped to all 2'b11 one cycle after start, plus a second start mid-frame → the frame reflects the pre-change snapshot, and exactly one frame is emitted.
- rst asserted during data byte 2 → the next cycle has tx_valid=0 and busy=0; a subsequent start emits a complete frame starting at A5.
